// File: rtl/button_pkg.sv
// Shared types and 50 MHz board-clock timing defaults for the push-button front end.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        HOLD_DELAY  = 2'd1,
        HOLD_REPEAT = 2'd2
    } btn_state_t;

    // 20 ms debounce, 0.5 s to first repeat, then 10 repeats per second
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_REPEAT_DELAY    = 25_000_000;
    localparam int DEF_REPEAT_PERIOD   = 5_000_000;

endpackage

// File: rtl/button_sync.sv
// Two-flop synchronizer for an asynchronous board input; both stages reset to 0.
module button_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Synchronizes, debounces and pulse-encodes a raw push-button, with auto-repeat while held.
module button_conditioner
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int ACTIVE_LOW      = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse,
    output logic step
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RP_W   = $clog2(RP_MAX + 1);

    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] DLY_LAST  = RP_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [RP_W-1:0] PER_LAST  = RP_W'(REPEAT_PERIOD - 1);
    localparam bit              REPEAT_EN = (REPEAT_DELAY != 0);

    logic pin_norm;
    logic sync;

    assign pin_norm = (ACTIVE_LOW != 0) ? ~btn_in : btn_in;

    button_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (pin_norm),
        .q   (sync)
    );

    logic [DB_W-1:0] db_cnt;
    logic            flip;
    logic            rise;
    logic            fall;

    assign flip = (sync != level) && (db_cnt == DB_LAST);
    assign rise = flip & ~level;
    assign fall = flip & level;

    // Any cycle of agreement between sync and level restarts the count
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt <= '0;
            level  <= 1'b0;
        end else if (sync == level) begin
            db_cnt <= '0;
        end else if (flip) begin
            db_cnt <= '0;
            level  <= ~level;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    btn_state_t      state;
    btn_state_t      state_next;
    logic [RP_W-1:0] rp_cnt;
    logic [RP_W-1:0] rp_next;
    logic            press_next;
    logic            release_next;
    logic            repeat_next;

    // A release checked before the repeat timeout so a coinciding timeout is dropped
    always_comb begin
        state_next   = state;
        rp_next      = rp_cnt;
        press_next   = 1'b0;
        release_next = 1'b0;
        repeat_next  = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    press_next = 1'b1;
                    rp_next    = '0;
                    state_next = HOLD_DELAY;
                end
            end
            HOLD_DELAY: begin
                if (fall) begin
                    release_next = 1'b1;
                    rp_next      = '0;
                    state_next   = IDLE;
                end else if (REPEAT_EN && (rp_cnt == DLY_LAST)) begin
                    repeat_next = 1'b1;
                    rp_next     = '0;
                    state_next  = HOLD_REPEAT;
                end else if (REPEAT_EN) begin
                    rp_next = rp_cnt + RP_W'(1);
                end
            end
            HOLD_REPEAT: begin
                if (fall) begin
                    release_next = 1'b1;
                    rp_next      = '0;
                    state_next   = IDLE;
                end else if (rp_cnt == PER_LAST) begin
                    repeat_next = 1'b1;
                    rp_next     = '0;
                end else begin
                    rp_next = rp_cnt + RP_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                rp_next    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            rp_cnt        <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
            step          <= 1'b0;
        end else begin
            state         <= state_next;
            rp_cnt        <= rp_next;
            press_pulse   <= press_next;
            release_pulse <= release_next;
            repeat_pulse  <= repeat_next;
            step          <= press_next | repeat_next;
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed and randomized bench for button_conditioner (active-high and active-low instances).
module tb_button_conditioner;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] pin = 2'b10;
    logic [1:0] lvl, prs, rls, rpt, stp;

    int checks = 0;
    int errors = 0;
    int t = 0;

    // reference model state, one slot per instance
    logic m_s1 [2];
    logic m_s2 [2];
    logic m_level [2];
    logic m_press [2];
    logic m_rel [2];
    logic m_rep [2];
    bit   m_hold [2];
    int   m_run [2];
    int   m_press_t [2];

    int n_press, n_rel, n_rep, n_lvl_hi, n_press1, n_rel1;
    int last_press_t, last_rel_t, first_rep_t, last_rep_t, last_press1_t;

    always #5 clk = ~clk;

    button_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .ACTIVE_LOW      (0)
    ) u_hi (
        .clk           (clk),
        .rst           (rst),
        .btn_in        (pin[0]),
        .level         (lvl[0]),
        .press_pulse   (prs[0]),
        .release_pulse (rls[0]),
        .repeat_pulse  (rpt[0]),
        .step          (stp[0])
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .ACTIVE_LOW      (1)
    ) u_lo (
        .clk           (clk),
        .rst           (rst),
        .btn_in        (pin[1]),
        .level         (lvl[1]),
        .press_pulse   (prs[1]),
        .release_pulse (rls[1]),
        .repeat_pulse  (rpt[1]),
        .step          (stp[1])
    );

    // Level flips after D consecutive disagreeing samples; repeats follow from elapsed time since press
    function automatic void model_edge(int i, logic p);
        logic seen;
        logic was;
        logic fl;
        int   k;
        if (rst) begin
            m_s1[i] = 1'b0; m_s2[i] = 1'b0; m_level[i] = 1'b0; m_run[i] = 0;
            m_hold[i] = 1'b0; m_press[i] = 1'b0; m_rel[i] = 1'b0; m_rep[i] = 1'b0;
            return;
        end
        seen    = m_s2[i];
        m_s2[i] = m_s1[i];
        m_s1[i] = p ^ (i == 1);
        was     = m_level[i];
        fl      = 1'b0;
        if (seen != was) begin
            m_run[i]++;
            if (m_run[i] == D) begin
                fl = 1'b1;
                m_run[i] = 0;
                m_level[i] = ~was;
            end
        end else begin
            m_run[i] = 0;
        end
        m_press[i] = fl && !was;
        m_rel[i]   = fl && was;
        m_rep[i]   = 1'b0;
        if (m_hold[i] && !m_rel[i]) begin
            k = t - m_press_t[i];
            m_rep[i] = (k == RD) || (k > RD && ((k - RD) % RP) == 0);
        end
        if (m_press[i]) begin
            m_hold[i] = 1'b1;
            m_press_t[i] = t;
        end
        if (m_rel[i]) m_hold[i] = 1'b0;
    endfunction

    task automatic check(string tag, logic obs, logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic checki(string tag, int obs, int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        n_press = 0; n_rel = 0; n_rep = 0; n_lvl_hi = 0; n_press1 = 0; n_rel1 = 0;
        last_press_t = -1; last_rel_t = -1; first_rep_t = -1; last_rep_t = -1; last_press1_t = -1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(0, pin[0]);
        model_edge(1, pin[1]);
        t++;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("level%0d@%0d", i, t), lvl[i], m_level[i]);
            check($sformatf("press%0d@%0d", i, t), prs[i], m_press[i]);
            check($sformatf("release%0d@%0d", i, t), rls[i], m_rel[i]);
            check($sformatf("repeat%0d@%0d", i, t), rpt[i], m_rep[i]);
            check($sformatf("step%0d@%0d", i, t), stp[i], m_press[i] | m_rep[i]);
        end
        n_lvl_hi += int'(lvl[0]);
        if (prs[0]) begin n_press++; last_press_t = t; end
        if (rls[0]) begin n_rel++; last_rel_t = t; end
        if (rpt[0]) begin
            if (n_rep == 0) first_rep_t = t;
            n_rep++;
            last_rep_t = t;
        end
        if (prs[1]) begin n_press1++; last_press1_t = t; end
        if (rls[1]) n_rel1++;
    endtask

    task automatic wait_press(string tag);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            tick();
            if (prs[0]) got = 1'b1;
        end
        checki(tag, int'(got), 1);
    endtask

    initial begin
        int s;
        int p;
        int dur [2];
        clear_counts();

        // reset with the active-low pin idling high
        repeat (3) tick();
        check("reset_level", lvl[0], 1'b0);
        check("reset_step", stp[0], 1'b0);
        rst = 1'b0;
        repeat (10) tick();
        checki("al_idle_no_press", n_press1, 0);

        // clean press
        clear_counts();
        s = t;
        pin[0] = 1'b1;
        repeat (8) tick();
        pin[0] = 1'b0;
        p = t;
        repeat (12) tick();
        checki("clean_press_cnt", n_press, 1);
        checki("clean_press_at", last_press_t - s, 6);
        checki("clean_repeat_cnt", n_rep, 0);
        checki("clean_release_cnt", n_rel, 1);
        checki("clean_release_at", last_rel_t - p, 6);

        // bounce
        clear_counts();
        pin[0] = 1'b1; repeat (3) tick();
        pin[0] = 1'b0; tick();
        pin[0] = 1'b1; repeat (3) tick();
        pin[0] = 1'b0; repeat (12) tick();
        checki("bounce_press_cnt", n_press, 0);
        checki("bounce_release_cnt", n_rel, 0);
        checki("bounce_level_hi", n_lvl_hi, 0);

        // hold with auto-repeat
        clear_counts();
        pin[0] = 1'b1;
        wait_press("hold_press_seen");
        p = t;
        repeat (30) tick();
        checki("hold_repeat_cnt", n_rep, 7);
        checki("hold_first_repeat", first_rep_t - p, RD);
        checki("hold_last_repeat", last_rep_t - p, RD + 6 * RP);
        pin[0] = 1'b0;
        repeat (12) tick();
        checki("hold_release_cnt", n_rel, 1);

        // release lands on a repeat timeout
        clear_counts();
        pin[0] = 1'b1;
        wait_press("coll_press_seen");
        repeat (7) tick();
        pin[0] = 1'b0;
        repeat (5) tick();
        tick();
        check("coll_release", rls[0], 1'b1);
        check("coll_no_repeat", rpt[0], 1'b0);
        check("coll_no_step", stp[0], 1'b0);
        checki("coll_repeat_cnt", n_rep, 1);
        repeat (10) tick();
        checki("coll_idle_no_repeat", n_rep, 1);

        // reset while in HOLD_REPEAT, button still held
        clear_counts();
        pin[0] = 1'b1;
        wait_press("rst_press_seen");
        repeat (12) tick();
        rst = 1'b1;
        tick();
        check("rst_level", lvl[0], 1'b0);
        check("rst_press", prs[0], 1'b0);
        check("rst_release", rls[0], 1'b0);
        check("rst_repeat", rpt[0], 1'b0);
        check("rst_step", stp[0], 1'b0);
        rst = 1'b0;
        clear_counts();
        s = t;
        repeat (6) tick();
        checki("rst_repress_cnt", n_press, 1);
        checki("rst_repress_at", last_press_t - s, 6);
        pin[0] = 1'b0;
        repeat (12) tick();

        // active-low press and release
        clear_counts();
        s = t;
        pin[1] = 1'b0;
        repeat (8) tick();
        checki("al_press_cnt", n_press1, 1);
        checki("al_press_at", last_press1_t - s, 6);
        pin[1] = 1'b1;
        repeat (10) tick();
        checki("al_release_cnt", n_rel1, 1);

        // randomized pin activity with occasional resets
        dur[0] = 1;
        dur[1] = 1;
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < 2; i++) begin
                dur[i]--;
                if (dur[i] == 0) begin
                    pin[i] = ~pin[i];
                    dur[i] = int'($urandom_range(1, 28));
                end
            end
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Front-end stage for a raw mechanical push-button. It synchronizes the asynchronous pin, debounces it, and emits clean single-cycle press, release and auto-repeat pulses. It sits directly upstream of the button counter: `step` drives that counter's increment input in place of the raw pin, so one physical press advances the count by exactly one. Holding the button advances it at a controlled repeat rate.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive cycles the synchronized input must differ from `level` before `level` flips (20 ms at 50 MHz); must be ≥1.
- `REPEAT_DELAY`, default 25_000_000: cycles from the press pulse to the first repeat pulse; 0 disables auto-repeat.
- `REPEAT_PERIOD`, default 5_000_000: cycles between subsequent repeat pulses; must be ≥1.
- `ACTIVE_LOW`, default 0: 1 means the pin reads 0 when pressed.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `btn_in`, in, 1: raw asynchronous button pin.
- `level`, out, 1: debounced state, 1 = pressed; registered.
- `press_pulse`, out, 1: 1-cycle pulse on debounced press.
- `release_pulse`, out, 1: 1-cycle pulse on debounced release.
- `repeat_pulse`, out, 1: 1-cycle pulse per auto-repeat tick.
- `step`, out, 1: `press_pulse | repeat_pulse`; feeds the downstream counter.

## Operation
- Polarity: the pin is XOR'd with `ACTIVE_LOW` before the synchronizer. Internally, 1 = pressed.
- Synchronizer: two flops, both reset to 0 (released). `sync` equals the normalized `btn_in` delayed by 2 cycles.
- Debounce counter `db_cnt`, width `$clog2(DEBOUNCE_CYCLES+1)`:
  - While `sync == level`, it clears to 0.
  - While `sync != level` and `db_cnt == DEBOUNCE_CYCLES-1`, `level` toggles and `db_cnt` clears.
  - Otherwise `db_cnt` increments.
  - Any single-cycle return to agreement restarts the count.
- Release FSM (`IDLE`, `HOLD_DELAY`, `HOLD_REPEAT`) and repeat timer `rp_cnt`, wide enough for max(`REPEAT_DELAY`, `REPEAT_PERIOD`):
  - `IDLE` → on a `level` 0→1 toggle: assert `press_pulse`, clear `rp_cnt`, go to `HOLD_DELAY`. If `REPEAT_DELAY`==0, `HOLD_DELAY` never times out.
  - `HOLD_DELAY`: `rp_cnt` increments. At `REPEAT_DELAY-1`: assert `repeat_pulse`, clear `rp_cnt`, go to `HOLD_REPEAT`.
  - `HOLD_REPEAT`: `rp_cnt` increments. At `REPEAT_PERIOD-1`: assert `repeat_pulse` and clear `rp_cnt`.
  - Any HOLD state → on a `level` 1→0 toggle: assert `release_pulse`, go to `IDLE`.
- Simultaneous events:
  - If release and a repeat timeout coincide, release wins and no `repeat_pulse` is issued.
  - `press_pulse` and `repeat_pulse` are never asserted in the same cycle.
- Reset values: `level`, all pulses, `step`, both sync flops, `db_cnt` and `rp_cnt` are 0; FSM is `IDLE`.
- Reset mid-operation: everything returns to its reset value on the next edge. A button still held when reset deasserts produces a fresh `press_pulse` after the full latency.

## Timing
- All outputs are registered. Pulses are exactly 1 cycle and coincide with the cycle in which `level` first shows its new value.
- Press/release latency is `DEBOUNCE_CYCLES + 2` rising edges from the first edge that samples the stable new pin value.
- Repeat timing:
  - First `repeat_pulse` is exactly `REPEAT_DELAY` cycles after `press_pulse`.
  - Subsequent repeats are every `REPEAT_PERIOD` cycles.
- No handshake: the downstream block must sample `step` every cycle.

## Structure
- Shared package `button_pkg`:
  - FSM state typedef `btn_state_t` (`IDLE`, `HOLD_DELAY`, `HOLD_REPEAT`).
  - Default timing constants for the 50 MHz board clock.
- Sub-module `button_sync`: 2-flop synchronizer with reset, reused for any other async board inputs.
- The debounce counter and repeat FSM stay in the top module.

## Test plan
Parameters for all scenarios: `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=3.
- Clean press: `btn_in` 0→1 at cycle 0, held for 8 cycles, then released → `level`=1 and `press_pulse`=1 at cycle 6 only; `step` mirrors it; no `repeat_pulse`; `release_pulse` 6 cycles after the pin falls.
- Bounce: pin high for 3 cycles, low for 1, high for 3, low → no pulses; `level` stays 0 throughout.
- Hold: pin held high for 30 cycles after `press_pulse` at cycle 6 → `repeat_pulse` at cycles 16, 19, 22, …; `step` asserts on each.
- Release/repeat collision: release timed so `level` falls on a repeat-timeout cycle → `release_pulse`=1, `repeat_pulse`=0, FSM `IDLE`.
- Reset mid-hold: `rst` for 1 cycle while in `HOLD_REPEAT` with the pin still high → all outputs 0 next cycle; new `press_pulse` exactly 6 cycles after `rst` deasserts.
- `ACTIVE_LOW`=1: pin 1→0 → `press_pulse` after 6 cycles; pin idle-high at reset produces no pulse.
